// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundles the signals between the core, the arbiter and the
// shared single-port memory.
//   core side   : i_read/i_addr (fetch request), d_read/d_write/d_addr/d_wdata
//                 (load/store request), i_ready/instr, d_ready/d_rdata (results)
//   memory side : mem_read/mem_write/mem_addr/mem_wdata (strobes and payload),
//                 mem_rdata/mem_ack (completion)
//   status      : err (sticky memory timeout)
// Modports: slave = the arbiter, master = the environment (core + memory).
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              i_read;
    logic [ADDR_W-1:0] i_addr;
    logic              d_read;
    logic              d_write;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;
    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              i_ready;
    logic [DATA_W-1:0] instr;
    logic              d_ready;
    logic [DATA_W-1:0] d_rdata;
    logic              err;

    modport slave (
        input  i_read, i_addr, d_read, d_write, d_addr, d_wdata,
        input  mem_rdata, mem_ack,
        output mem_read, mem_write, mem_addr, mem_wdata,
        output i_ready, instr, d_ready, d_rdata, err
    );

    modport master (
        output i_read, i_addr, d_read, d_write, d_addr, d_wdata,
        output mem_rdata, mem_ack,
        input  mem_read, mem_write, mem_addr, mem_wdata,
        input  i_ready, instr, d_ready, d_rdata, err
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory bus between the instruction-fetch
// port and the load/store port of the core. Data accesses win over fetches,
// one access is in flight at a time, and a watchdog aborts an access whose
// mem_ack never arrives (sticky err).
// Ports:
//   clk  - system clock, rising edge
//   nrst - asynchronous active-low reset
//   bus  - mem_arbiter_if.slave: requests/results to the core, strobes/ack
//          to the memory, err status. All outputs are registered.
module mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16   // legal range 2..255
) (
    input logic          clk,
    input logic          nrst,
    mem_arbiter_if.slave bus
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] DATA  = 2'd1;
    localparam logic [1:0] FETCH = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);

    logic [1:0]        state;
    logic [7:0]        wd;
    logic              d_req;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] rdata;

    always_comb begin
        d_req    = bus.d_read | bus.d_write;
        req_addr = d_req ? bus.d_addr : bus.i_addr;
        rdata    = bus.mem_rdata;
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state         <= IDLE;
            wd            <= '0;
            bus.mem_read  <= 1'b0;
            bus.mem_write <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.i_ready   <= 1'b0;
            bus.d_ready   <= 1'b0;
            bus.instr     <= '0;
            bus.d_rdata   <= '0;
            bus.err       <= 1'b0;
        end else begin
            // Ready strobes are single-cycle; only the completing branch sets one.
            bus.i_ready <= 1'b0;
            bus.d_ready <= 1'b0;
            case (state)
                IDLE: begin
                    wd <= '0;
                    if (d_req) begin
                        state         <= DATA;
                        bus.mem_addr  <= req_addr;
                        bus.mem_wdata <= bus.d_wdata;
                        bus.mem_write <= bus.d_write;
                        bus.mem_read  <= ~bus.d_write;   // store wins over load
                    end else if (bus.i_read) begin
                        state        <= FETCH;
                        bus.mem_addr <= req_addr;
                        bus.mem_read <= 1'b1;
                    end
                end
                DATA, FETCH: begin
                    if (bus.mem_ack || (wd == WD_LAST)) begin
                        bus.mem_read  <= 1'b0;
                        bus.mem_write <= 1'b0;
                        wd            <= '0;
                        state         <= DONE;
                        if (!bus.mem_ack) begin
                            // Abort: core proceeds with stale data, err records it.
                            bus.err <= 1'b1;
                        end
                        if (state == FETCH) begin
                            bus.i_ready <= 1'b1;
                            if (bus.mem_ack) begin
                                bus.instr <= rdata;
                            end
                        end else begin
                            bus.d_ready <= 1'b1;
                            // mem_read is still the live strobe here, so it marks a load.
                            if (bus.mem_ack && bus.mem_read) begin
                                bus.d_rdata <= rdata;
                            end
                        end
                    end else begin
                        wd <= wd + 8'd1;
                    end
                end
                DONE: begin
                    // One dead cycle lets the core move past the request just served.
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed bench for mem_arbiter with a behavioural memory
// (programmable ack delay, 0 = never ack) and a scoreboard of expected
// ready/data results checked whenever a ready pulse appears.
module tb_mem_arbiter;
    logic clk = 1'b0;
    logic nrst;

    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(16)) dut (
        .clk  (clk),
        .nrst (nrst),
        .bus  (bus)
    );

    typedef struct {
        logic        is_fetch;
        logic [31:0] data;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        rd;
        logic        wr;
    } acc_t;

    exp_t sb[$];
    acc_t acc_log[$];

    int unsigned vectors    = 0;
    int unsigned miscompares = 0;
    int unsigned ack_delay  = 1;
    bit          spurious   = 1'b0;
    int unsigned busy       = 0;
    int unsigned last_len   = 0;
    int unsigned unstable   = 0;
    int unsigned i_pulses   = 0;
    int unsigned d_pulses   = 0;
    logic        prev_ready = 1'b0;

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        case (a)
            32'h0000_0004: return 32'h3E80_0093;
            32'h0000_0100: return 32'hDEAD_BEEF;
            default:       return a ^ 32'hC0DE_0000;
        endcase
    endfunction

    function automatic acc_t last_acc(input int unsigned back);
        acc_t z;
        z = '{addr: 32'h0, wdata: 32'h0, rd: 1'b0, wr: 1'b0};
        if (acc_log.size() > back) return acc_log[acc_log.size() - 1 - back];
        return z;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input string tag);
        int unsigned n = 0;
        do begin
            tick();
            n++;
        end while (!(bus.i_ready || bus.d_ready) && n < 60);
        chk({tag, "_ready_seen"}, {31'b0, bus.i_ready | bus.d_ready}, 32'd1);
    endtask

    // Memory model: acks after ack_delay strobe cycles, logs each access,
    // and notes any change of address/data while a strobe is held.
    initial begin
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 32'h0;
        forever begin
            @(posedge clk);
            #2;
            if (bus.mem_read || bus.mem_write) begin
                if (busy == 0) begin
                    acc_log.push_back('{addr: bus.mem_addr, wdata: bus.mem_wdata,
                                        rd: bus.mem_read, wr: bus.mem_write});
                end else if (acc_log[$].addr !== bus.mem_addr || acc_log[$].wdata !== bus.mem_wdata ||
                             acc_log[$].rd !== bus.mem_read || acc_log[$].wr !== bus.mem_write) begin
                    unstable++;
                end
                busy++;
                if (ack_delay != 0 && busy == ack_delay) begin
                    bus.mem_ack   = 1'b1;
                    bus.mem_rdata = mem_fn(bus.mem_addr);
                end else begin
                    bus.mem_ack   = 1'b0;
                    bus.mem_rdata = 32'h0BAD_0BAD;
                end
            end else begin
                if (busy != 0) last_len = busy;
                busy = 0;
                bus.mem_ack   = spurious;
                bus.mem_rdata = spurious ? 32'hBADB_AD00 : 32'h0;
            end
        end
    end

    // Scoreboard monitor: every ready pulse must match the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #3;
            if (bus.i_ready || bus.d_ready) begin
                if (bus.i_ready) i_pulses++;
                if (bus.d_ready) d_pulses++;
                chk("ready_one_cycle", {31'b0, prev_ready}, 32'd0);
                chk("ready_expected", {31'b0, sb.size() != 0}, 32'd1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("ready_kind", {30'b0, bus.i_ready, bus.d_ready}, e.is_fetch ? 32'd2 : 32'd1);
                    chk(e.is_fetch ? "instr" : "d_rdata", e.is_fetch ? bus.instr : bus.d_rdata, e.data);
                end
            end
            prev_ready = bus.i_ready | bus.d_ready;
        end
    end

    initial begin
        int unsigned p0;
        int unsigned n0;
        acc_t a;

        bus.i_read  = 1'b0;
        bus.i_addr  = 32'h0;
        bus.d_read  = 1'b0;
        bus.d_write = 1'b0;
        bus.d_addr  = 32'h0;
        bus.d_wdata = 32'h0;
        nrst = 1'b1;
        #1 nrst = 1'b0;
        #10;
        chk("rst_strobes", {30'b0, bus.mem_read, bus.mem_write}, 32'd0);
        chk("rst_addr", bus.mem_addr, 32'h0);
        chk("rst_wdata", bus.mem_wdata, 32'h0);
        chk("rst_ready", {30'b0, bus.i_ready, bus.d_ready}, 32'd0);
        chk("rst_instr", bus.instr, 32'h0);
        chk("rst_d_rdata", bus.d_rdata, 32'h0);
        chk("rst_err", {31'b0, bus.err}, 32'd0);
        @(negedge clk);
        nrst = 1'b1;
        tick();

        // Single fetch, ack one cycle after the strobe.
        ack_delay = 1;
        n0 = acc_log.size();
        bus.i_addr = 32'h4;
        bus.i_read = 1'b1;
        sb.push_back('{is_fetch: 1'b1, data: 32'h3E80_0093});
        wait_ready("t1");
        bus.i_read = 1'b0;
        tick();
        a = last_acc(0);
        chk("t1_nacc", acc_log.size(), n0 + 1);
        chk("t1_addr", a.addr, 32'h4);
        chk("t1_rd", {30'b0, a.rd, a.wr}, 32'd2);
        chk("t1_strobe_len", last_len, 32'd1);
        chk("t1_instr_held", bus.instr, 32'h3E80_0093);
        chk("t1_no_d_ready", d_pulses, 32'd0);

        // Load and fetch requested together: load first, DONE gap, then fetch.
        bus.i_addr = 32'h8;
        bus.i_read = 1'b1;
        bus.d_addr = 32'h100;
        bus.d_read = 1'b1;
        sb.push_back('{is_fetch: 1'b0, data: 32'hDEAD_BEEF});
        sb.push_back('{is_fetch: 1'b1, data: mem_fn(32'h8)});
        wait_ready("t2_load");
        bus.d_read = 1'b0;
        chk("t2_data_first", {31'b0, bus.d_ready}, 32'd1);
        tick();
        chk("t2_done_gap", {31'b0, bus.mem_read}, 32'd0);
        tick();
        chk("t2_fetch_rd", {31'b0, bus.mem_read}, 32'd1);
        chk("t2_fetch_addr", bus.mem_addr, 32'h8);
        wait_ready("t2_fetch");
        bus.i_read = 1'b0;
        tick();
        chk("t2_first_addr", last_acc(1).addr, 32'h100);
        chk("t2_second_addr", last_acc(0).addr, 32'h8);

        // Store with read also raised, ack after 4 strobe cycles.
        ack_delay = 4;
        bus.d_addr  = 32'h200;
        bus.d_wdata = 32'h1234_5678;
        bus.d_write = 1'b1;
        bus.d_read  = 1'b1;
        sb.push_back('{is_fetch: 1'b0, data: 32'hDEAD_BEEF});
        wait_ready("t3");
        bus.d_write = 1'b0;
        bus.d_read  = 1'b0;
        tick();
        a = last_acc(0);
        chk("t3_strobes", {30'b0, a.rd, a.wr}, 32'd1);
        chk("t3_addr", a.addr, 32'h200);
        chk("t3_wdata", a.wdata, 32'h1234_5678);
        chk("t3_strobe_len", last_len, 32'd4);
        chk("t3_stable", unstable, 32'd0);

        // No ack: watchdog abort after 16 strobe cycles, err sticky.
        ack_delay = 0;
        bus.i_addr = 32'h40;
        bus.i_read = 1'b1;
        sb.push_back('{is_fetch: 1'b1, data: mem_fn(32'h8)});
        wait_ready("t4_timeout");
        bus.i_read = 1'b0;
        chk("t4_err_set", {31'b0, bus.err}, 32'd1);
        tick();
        chk("t4_strobe_len", last_len, 32'd16);
        chk("t4_strobe_dropped", {31'b0, bus.mem_read}, 32'd0);
        ack_delay = 2;
        bus.i_addr = 32'h44;
        bus.i_read = 1'b1;
        sb.push_back('{is_fetch: 1'b1, data: mem_fn(32'h44)});
        wait_ready("t4_recover");
        bus.i_read = 1'b0;
        tick();
        chk("t4_err_sticky", {31'b0, bus.err}, 32'd1);

        // Fetch request held through three back-to-back services.
        ack_delay = 1;
        p0 = i_pulses;
        n0 = acc_log.size();
        bus.i_addr = 32'h80;
        bus.i_read = 1'b1;
        for (int k = 0; k < 3; k++) sb.push_back('{is_fetch: 1'b1, data: mem_fn(32'h80)});
        for (int k = 0; k < 3; k++) wait_ready("t5_b2b");
        bus.i_read = 1'b0;
        tick();
        tick();
        chk("t5_pulses", i_pulses - p0, 32'd3);
        chk("t5_accesses", acc_log.size(), n0 + 3);

        // Spurious ack while idle: nothing captured, no ready.
        spurious = 1'b1;
        tick();
        tick();
        tick();
        spurious = 1'b0;
        tick();
        chk("t5_spur_instr", bus.instr, mem_fn(32'h80));
        chk("t5_spur_d_rdata", bus.d_rdata, 32'hDEAD_BEEF);
        chk("t5_spur_idle", {30'b0, bus.mem_read, bus.mem_write}, 32'd0);
        chk("t5_spur_pulses", i_pulses - p0, 32'd3);

        // Reset in the middle of a fetch.
        ack_delay = 0;
        bus.i_addr = 32'h300;
        bus.i_read = 1'b1;
        tick();
        tick();
        tick();
        chk("t6_in_fetch", {31'b0, bus.mem_read}, 32'd1);
        #2 nrst = 1'b0;
        #1;
        chk("t6_rst_strobe", {30'b0, bus.mem_read, bus.mem_write}, 32'd0);
        chk("t6_rst_addr", bus.mem_addr, 32'h0);
        chk("t6_rst_data", bus.instr | bus.d_rdata, 32'h0);
        chk("t6_rst_flags", {29'b0, bus.err, bus.i_ready, bus.d_ready}, 32'd0);
        bus.i_read = 1'b0;
        @(negedge clk);
        nrst = 1'b1;
        tick();
        ack_delay = 1;
        bus.i_addr = 32'h304;
        bus.i_read = 1'b1;
        sb.push_back('{is_fetch: 1'b1, data: mem_fn(32'h304)});
        wait_ready("t6_after");
        bus.i_read = 1'b0;
        tick();
        chk("t6_after_addr", last_acc(0).addr, 32'h304);
        chk("t6_err_clear", {31'b0, bus.err}, 32'd0);
        chk("sb_drained", sb.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
